// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver stage.
// UART_TX_PARITY_EN adds the parity bit to the frame-length constant.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_OVERSAMPLE = 8;
  localparam int UART_DATA_SIZE  = 8;

`ifdef UART_TX_PARITY_EN
  localparam int UART_PARITY_BITS = 1;
`else
  localparam int UART_PARITY_BITS = 0;
`endif

  localparam int UART_FRAME_BITS = 1 + UART_DATA_SIZE + UART_PARITY_BITS + 1;

  function automatic int uart_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Producer-side valid/ready handshake for the UART transmitter.
interface uart_transmitter_if #(
  parameter int DATA_SIZE = 8
) ();

  logic                 tx_valid;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Oversample counter that marks the last clock cycle of every bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic bclk_x8,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int            CW   = uart_cnt_width(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_sample_counter;

  always_ff @(posedge bclk_x8) begin
    if (!rst) begin
      r_sample_counter <= '0;
    end else if (i_clear || (r_sample_counter == LAST)) begin
      r_sample_counter <= '0;
    end else begin
      r_sample_counter <= r_sample_counter + ONE;
    end
  end

  assign o_bit_end = (r_sample_counter == LAST) && !i_clear;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: valid/ready word in, OVERSAMPLE-cycle bits out.
// Defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_SIZE  = UART_DATA_SIZE,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic              bclk_x8,
  input  logic              rst,
  uart_transmitter_if.slave tx_if,
  output logic              tx_serial,
  output logic              tx_status,
  output logic              tx_done
);

  localparam int            BW        = uart_cnt_width(DATA_SIZE);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_SIZE - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic          LAST_STOP = (STOP_BITS > 1) ? 1'b1 : 1'b0;

  uart_state_e          r_state, w_next_state;
  logic [DATA_SIZE-1:0] r_shift, w_next_shift;
  logic [BW-1:0]        r_bit_counter, w_next_bit_counter;
  logic                 r_stop_counter, w_next_stop_counter;
  logic                 r_serial, w_next_serial;
  logic                 r_done, w_next_done;
  logic                 r_status;
  logic                 w_bit_end;
  logic                 w_accept;
  logic                 w_timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_next_parity;
`endif

  assign tx_if.tx_ready = (r_state == IDLE) && rst;
  assign w_accept       = tx_if.tx_valid && tx_if.tx_ready;
  assign w_timer_clear  = (r_state == IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .bclk_x8  (bclk_x8),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .o_bit_end(w_bit_end)
  );

  // The line level is computed for the state being entered so tx_serial can be a flop.
  always_comb begin
    w_next_state        = r_state;
    w_next_shift        = r_shift;
    w_next_bit_counter  = r_bit_counter;
    w_next_stop_counter = r_stop_counter;
    w_next_serial       = 1'b1;
    w_next_done         = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_next_parity       = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state        = START;
          w_next_shift        = tx_if.tx_data;
          w_next_bit_counter  = '0;
          w_next_stop_counter = 1'b0;
          w_next_serial       = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_next_parity       = ^tx_if.tx_data;
`endif
        end else begin
          w_next_serial = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_next_state  = DATA;
          w_next_serial = r_shift[0];
        end else begin
          w_next_serial = 1'b0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_counter == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_next_state  = PARITY;
            w_next_serial = r_parity;
`else
            w_next_state  = STOP;
            w_next_serial = 1'b1;
`endif
          end else begin
            w_next_shift       = {1'b0, r_shift[DATA_SIZE-1:1]};
            w_next_bit_counter = r_bit_counter + BIT_ONE;
            w_next_serial      = r_shift[1];
          end
        end else begin
          w_next_serial = r_shift[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_next_state  = STOP;
          w_next_serial = 1'b1;
        end else begin
          w_next_serial = r_parity;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_counter == LAST_STOP) begin
            w_next_state = IDLE;
            w_next_done  = 1'b1;
          end else begin
            w_next_stop_counter = 1'b1;
          end
        end else begin
          w_next_stop_counter = r_stop_counter;
        end
        w_next_serial = 1'b1;
      end
      default: begin
        w_next_state  = IDLE;
        w_next_serial = 1'b1;
      end
    endcase
  end

  // Reset abandons any frame in flight and parks the line high without a done pulse.
  always_ff @(posedge bclk_x8) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_bit_counter  <= '0;
      r_stop_counter <= 1'b0;
      r_serial       <= 1'b1;
      r_status       <= 1'b0;
      r_done         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity       <= 1'b0;
`endif
    end else begin
      r_state        <= w_next_state;
      r_shift        <= w_next_shift;
      r_bit_counter  <= w_next_bit_counter;
      r_stop_counter <= w_next_stop_counter;
      r_serial       <= w_next_serial;
      r_status       <= (w_next_state != IDLE);
      r_done         <= w_next_done;
`ifdef UART_TX_PARITY_EN
      r_parity       <= w_next_parity;
`endif
    end
  end

  assign tx_serial = r_serial;
  assign tx_status = r_status;
  assign tx_done   = r_done;

endmodule
